// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan driver.
//   - Glyph constants for SEG (active-low, bit7 = DP, bits[6:0] = {g,f,e,d,c,b,a}).
//   - Internal 5-bit display codes: 0..15 hex digits, 16 blank, 17 dash.
//   - Conversion FSM state encoding.
//   - glyph(): display code to SEG pattern.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] disp_code_t;
    localparam disp_code_t CODE_BLANK = 5'd16;
    localparam disp_code_t CODE_DASH  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] glyph(input disp_code_t code);
        case (code)
            5'd0:       glyph = SEG_0;
            5'd1:       glyph = SEG_1;
            5'd2:       glyph = SEG_2;
            5'd3:       glyph = SEG_3;
            5'd4:       glyph = SEG_4;
            5'd5:       glyph = SEG_5;
            5'd6:       glyph = SEG_6;
            5'd7:       glyph = SEG_7;
            5'd8:       glyph = SEG_8;
            5'd9:       glyph = SEG_9;
            5'd10:      glyph = SEG_A;
            5'd11:      glyph = SEG_B;
            5'd12:      glyph = SEG_C;
            5'd13:      glyph = SEG_D;
            5'd14:      glyph = SEG_E;
            5'd15:      glyph = SEG_F;
            CODE_DASH:  glyph = SEG_DASH;
            default:    glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: value/mode inputs and display outputs of the scan driver.
//   mod        1 = hex display, 0 = unsigned decimal display
//   data[31:0] value to display
//   SEG[7:0]   segments, active-low (bit7 = DP)
//   AN[7:0]    digit enables, active-low, AN[0] = rightmost digit
//   conv_busy  high while a decimal conversion is in progress
// master: the side supplying mod/data; slave: the driver itself.
interface seg_scan_driver_if;
    logic        mod;
    logic [31:0] data;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        conv_busy;

    modport master (output mod, data, input SEG, AN, conv_busy);
    modport slave  (input mod, data, output SEG, AN, conv_busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 32-bit binary to 10-digit BCD converter (double dabble).
//   clk, clr    clock, asynchronous active-low reset
//   start       1 = run free-running conversions, 0 = abort and hold in IDLE
//   bin[31:0]   value sampled in IDLE
//   busy        high from the capture edge until the commit edge (33 clks)
//   done        high during the COMMIT cycle; bcd is valid then
//   bcd[39:0]   accumulator, ten BCD digits
// One conversion: IDLE (capture) -> 32 x SHIFT -> COMMIT -> IDLE, 34 clks.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);

    conv_state_t state, state_nx;
    logic [31:0] shreg;
    logic [39:0] acc;
    logic [39:0] acc_adj;
    logic [4:0]  bit_cnt;

    // Add-3 correction; a corrected nibble is at most 12, so nothing carries
    // into the neighbouring digit.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < 10; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        if (!start) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nx = ST_SHIFT;
                ST_SHIFT:  if (bit_cnt == 5'd31) state_nx = ST_COMMIT;
                ST_COMMIT: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        acc     <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    {acc, shreg} <= {acc_adj[38:0], shreg, 1'b0};
                    bit_cnt      <= bit_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_COMMIT);
    assign bcd  = acc;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit multiplexed seven-segment driver.
//   clk        board clock
//   clr        asynchronous active-low reset
//   bus        seg_scan_driver_if.slave: mod, data in; SEG, AN, conv_busy out
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   BLANK_LZ   1 = blank leading zeros in decimal mode
// Hex mode copies data nibbles into the display register every clk. Decimal
// mode loads the display register only when a conversion commits, so digits
// never show a partial value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic                clk,
    input logic                clr,
    seg_scan_driver_if.slave   bus
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;
    logic [7:0]       seg_q;
    logic [7:0]       an_q;
    disp_code_t       disp [8];
    disp_code_t       dec_code [8];

    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [39:0] conv_bcd;

    assign conv_start = ~bus.mod;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .clr   (clr),
        .start (conv_start),
        .bin   (bus.data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Decimal digit codes: dashes on overflow (BCD digit 8 or 9 nonzero),
    // otherwise the low eight digits with optional leading-zero blanking.
    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        logic leading;
        leading = BLANK_LZ;
        for (int i = 7; i >= 0; i--) begin
            dec_code[i] = {1'b0, conv_bcd[4*i +: 4]};
            if (leading && (i != 0) && (conv_bcd[4*i +: 4] == 4'd0))
                dec_code[i] = CODE_BLANK;
            else
                leading = 1'b0;
        end
        if (|conv_bcd[39:32]) begin
            for (int i = 0; i < 8; i++)
                dec_code[i] = CODE_DASH;
        end
    end

    // NOTE: the display register array is small and must come up blank, so it
    // is reset explicitly rather than treated as an uninitialised memory.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= 8'hFF;
            for (int i = 0; i < 8; i++)
                disp[i] <= CODE_BLANK;
        end else begin
            if (scan_cnt == CNT_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            an_q  <= ~(8'b1 << idx);
            seg_q <= glyph(disp[idx]);

            // Hex wins over a coincident commit, which is how a mode switch
            // aborts a conversion without its result ever reaching the digits.
            if (bus.mod) begin
                for (int i = 0; i < 8; i++)
                    disp[i] <= {1'b0, bus.data[4*i +: 4]};
            end else if (conv_done) begin
                for (int i = 0; i < 8; i++)
                    disp[i] <= dec_code[i];
            end
        end
    end

    assign bus.SEG       = seg_q;
    assign bus.AN        = an_q;
    assign bus.conv_busy = conv_busy;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver (SCAN_DIV = 4).
// Two instances share clk/clr/mod/data: dut_a blanks leading zeros, dut_b
// does not. Expected frames come from an arithmetic reference model.
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic clr;

    seg_scan_driver_if bus_a ();
    seg_scan_driver_if bus_b ();

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_a (
        .clk (clk),
        .clr (clr),
        .bus (bus_a)
    );

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_b (
        .clk (clk),
        .clr (clr),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] glyph_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [31:0] d);
        bus_a.mod  = m;
        bus_a.data = d;
        bus_b.mod  = m;
        bus_b.data = d;
    endtask

    // Expected SEG per digit, packed {digit7, ..., digit0}.
    function automatic logic [63:0] model(input bit hex, input logic [31:0] v, input bit blz);
        logic [63:0]     r;
        longint unsigned uv;
        longint unsigned p;
        r  = '0;
        uv = v;
        p  = 1;
        for (int i = 0; i < 8; i++) begin
            if (hex)
                r[8*i +: 8] = glyph_tab[v[4*i +: 4]];
            else if (uv >= 64'd100000000)
                r[8*i +: 8] = 8'hBF;
            else if (blz && i > 0 && uv < p)
                r[8*i +: 8] = 8'hFF;
            else
                r[8*i +: 8] = glyph_tab[int'((uv / p) % 10)];
            p = p * 10;
        end
        return r;
    endfunction

    // Collects the SEG pattern shown for each digit over one scan frame.
    task automatic read_frame(input bit sel_b, output logic [63:0] frame);
        logic [7:0] seen;
        logic [7:0] an;
        logic [7:0] seg;
        seen  = '0;
        frame = '1;
        for (int t = 0; t < 64 && seen != 8'hFF; t++) begin
            @(negedge clk);
            an  = sel_b ? bus_b.AN  : bus_a.AN;
            seg = sel_b ? bus_b.SEG : bus_a.SEG;
            for (int k = 0; k < 8; k++) begin
                if (an == ~(8'b1 << k)) begin
                    frame[8*k +: 8] = seg;
                    seen[k]         = 1'b1;
                end
            end
        end
        check("frame_digits_seen", {56'd0, seen}, 64'hFF);
    endtask

    // Waits for the next busy 1 -> 0 transition (a commit), bounded.
    task automatic wait_commit();
        int t;
        t = 0;
        while (bus_a.conv_busy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (bus_a.conv_busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("commit_within_bound", {63'd0, (t < 200)}, 64'd1);
    endtask

    task automatic dec_case(input string tag, input logic [31:0] v);
        logic [63:0] f;
        drive(1'b0, v);
        wait_commit();
        wait_commit();
        read_frame(1'b0, f);
        check(tag, f, model(1'b0, v, 1'b1));
        read_frame(1'b1, f);
        check({tag, "_nolz"}, f, model(1'b0, v, 1'b0));
    endtask

    task automatic hex_case(input string tag, input logic [31:0] v);
        logic [63:0] f;
        drive(1'b1, v);
        repeat (2) @(negedge clk);
        check({tag, "_busy"}, {63'd0, bus_a.conv_busy}, 64'd0);
        read_frame(1'b0, f);
        check(tag, f, model(1'b1, v, 1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lo;
        int cnt;
        logic [31:0] rv;
        logic [63:0] f;

        // Reset state
        clr = 1'b0;
        drive(1'b1, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_seg", {56'd0, bus_a.SEG}, 64'hFF);
        check("rst_an", {56'd0, bus_a.AN}, 64'hFF);
        check("rst_busy", {63'd0, bus_a.conv_busy}, 64'd0);

        // Scan sequence: each digit held SCAN_DIV clks, wraps after digit 7
        clr = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            check("scan_an", {56'd0, bus_a.AN}, {56'd0, ~(8'b1 << ((n / SCAN_DIV) % 8))});
        end

        // Hex mode
        hex_case("hex_1234ABCF", 32'h1234ABCF);

        // Decimal: busy high 33 clks, low 1 clk
        drive(1'b0, 32'd12345678);
        cnt = 0;
        while (bus_a.conv_busy !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        hi = 0;
        while (bus_a.conv_busy === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (bus_a.conv_busy === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("busy_high_clks", 64'(hi), 64'd33);
        check("busy_low_clks", 64'(lo), 64'd1);

        dec_case("dec_12345678", 32'd12345678);
        dec_case("dec_305", 32'd305);
        dec_case("dec_0", 32'd0);
        dec_case("dec_99999999", 32'd99999999);
        dec_case("dec_100000000", 32'd100000000);
        dec_case("dec_ffffffff", 32'hFFFFFFFF);

        // Randomized values
        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0:       rv = $urandom_range(0, 999);
                1:       rv = $urandom_range(0, 99999999);
                default: rv = $urandom;
            endcase
            dec_case("dec_rand", rv);
        end
        for (int r = 0; r < 3; r++) begin
            rv = $urandom;
            hex_case("hex_rand", rv);
        end

        // Abort: mod 0 -> 1 at SHIFT cycle 10
        dec_case("dec_555", 32'd555);
        wait_commit();
        @(negedge clk);
        check("abort_in_shift", {63'd0, bus_a.conv_busy}, 64'd1);
        repeat (10) @(negedge clk);
        drive(1'b1, 32'hDEADBEEF);
        @(negedge clk);
        check("abort_busy_next", {63'd0, bus_a.conv_busy}, 64'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_a.conv_busy !== 1'b0) cnt++;
        end
        check("abort_busy_stays_low", 64'(cnt), 64'd0);
        read_frame(1'b0, f);
        check("abort_hex_shown", f, model(1'b1, 32'hDEADBEEF, 1'b1));

        // Reset pulse at SHIFT cycle 20
        drive(1'b0, 32'd87654321);
        wait_commit();
        @(negedge clk);
        repeat (20) @(negedge clk);
        clr = 1'b0;
        #1;
        check("midreset_seg", {56'd0, bus_a.SEG}, 64'hFF);
        check("midreset_an", {56'd0, bus_a.AN}, 64'hFF);
        check("midreset_busy", {63'd0, bus_a.conv_busy}, 64'd0);
        drive(1'b0, 32'd2024);
        @(negedge clk);
        clr = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_a.SEG !== 8'hFF) cnt++;
        end
        check("no_stale_after_reset", 64'(cnt), 64'd0);
        wait_commit();
        read_frame(1'b0, f);
        check("first_commit_after_reset", f, model(1'b0, 32'd2024, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
